// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit common-anode seven-segment display.
// Words are double-buffered and swapped only at frame boundaries so a frame never tears.
module sevenseg_scan_ctrl #(
    parameter int DIGITS    = 8,
    parameter int DIV       = 50000,
    parameter int BLANK_CYC = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] data_in,
    input  logic        load,
    input  logic        blank_lz,
    input  logic [7:0]  dp_mask,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int              CNT_W     = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);
    localparam logic [2:0]       IDX_LAST  = 3'(DIGITS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [31:0]      shadow_q, shadow_d;
    logic [31:0]      pending_q, pending_d;
    logic             pend_v_q, pend_v_d;
    logic [7:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             frame_done_q, frame_done_d;

    logic             slot_end;
    logic             boundary;
    logic [3:0]       nib;
    logic [7:0]       lz_bits;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        case (n)
            4'h0: hex_to_seg = 7'h40;
            4'h1: hex_to_seg = 7'h79;
            4'h2: hex_to_seg = 7'h24;
            4'h3: hex_to_seg = 7'h30;
            4'h4: hex_to_seg = 7'h19;
            4'h5: hex_to_seg = 7'h12;
            4'h6: hex_to_seg = 7'h02;
            4'h7: hex_to_seg = 7'h78;
            4'h8: hex_to_seg = 7'h00;
            4'h9: hex_to_seg = 7'h10;
            4'hA: hex_to_seg = 7'h08;
            4'hB: hex_to_seg = 7'h03;
            4'hC: hex_to_seg = 7'h46;
            4'hD: hex_to_seg = 7'h21;
            4'hE: hex_to_seg = 7'h04;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

    // Bit i set when nibbles i..DIGITS-1 are all zero; digit 0 is never blanked.
    function automatic logic [7:0] lz_mask(input logic [31:0] word);
        logic [7:0] m;
        logic       all_zero;
        m        = '0;
        all_zero = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            if (i < DIGITS) begin
                all_zero = all_zero & (word[i*4 +: 4] == 4'd0);
                m[i]     = all_zero;
            end
        end
        m[0] = 1'b0;
        return m;
    endfunction

    always_comb begin
        slot_end     = (cnt_q == CNT_LAST);
        boundary     = enable && slot_end && (idx_q == IDX_LAST);
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        pend_v_d     = pend_v_q;

        if (!enable) begin
            cnt_d = '0;
            idx_d = '0;
            // While dark there is no frame to protect, so the latest word goes straight through.
            if (load) begin
                shadow_d  = data_in;
                pending_d = data_in;
                pend_v_d  = 1'b0;
            end else if (pend_v_q) begin
                shadow_d = pending_q;
                pend_v_d = 1'b0;
            end
        end else begin
            if (slot_end) begin
                cnt_d = '0;
                idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end

            if (load && boundary) begin
                shadow_d = data_in;
                pend_v_d = 1'b0;
            end else if (load) begin
                pending_d = data_in;
                pend_v_d  = 1'b1;
            end else if (boundary && pend_v_q) begin
                shadow_d = pending_q;
                pend_v_d = 1'b0;
            end
        end
    end

    always_comb begin
        nib          = shadow_q[{idx_q, 2'b00} +: 4];
        lz_bits      = lz_mask(shadow_q);
        an_d         = 8'hFF;
        seg_d        = 7'h7F;
        dp_d         = 1'b1;
        frame_done_d = boundary;

        // Guard cycles keep all anodes off while the segment lines settle to the next digit.
        if (enable && (cnt_q >= BLANK_LIM)) begin
            an_d  = ~(8'd1 << idx_q);
            seg_d = (blank_lz && lz_bits[idx_q]) ? 7'h7F : hex_to_seg(nib);
            dp_d  = ~dp_mask[idx_q];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            pending_q    <= '0;
            pend_v_q     <= 1'b0;
            an_q         <= 8'hFF;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            pend_v_q     <= pend_v_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Bench for sevenseg_scan_ctrl: a cycle model feeds an expected-output queue every edge,
// plus directed frame walks for the scan order, leading-zero blanking, loads and enable.
module tb_sevenseg_scan_ctrl;

    localparam int DIGITS = 8;
    localparam int DIV    = 4;
    localparam int BLANK  = 1;
    localparam int FRAME  = DIGITS * DIV;

    localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h04, 7'h0E};

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] data_in = '0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [7:0]  dp_mask = '0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [16:0] exp_q [$];
    int          m_pos = 0;
    logic [31:0] m_shadow = '0;
    logic [31:0] m_pend = '0;
    logic        m_pv = 1'b0;

    sevenseg_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV), .BLANK_CYC(BLANK)) dut (
        .clock(clock), .reset(reset), .enable(enable), .data_in(data_in), .load(load),
        .blank_lz(blank_lz), .dp_mask(dp_mask), .an(an), .seg(seg), .dp(dp),
        .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Expected {an, seg, dp, frame_done} for the edge about to happen, from the model's position.
    function automatic logic [16:0] model_out();
        int         slot;
        int         ph;
        logic       fd;
        logic [3:0] nibv;
        logic [6:0] s;
        if (reset || !enable) return {8'hFF, 7'h7F, 1'b1, 1'b0};
        slot = m_pos / DIV;
        ph   = m_pos % DIV;
        fd   = (m_pos == FRAME - 1);
        if (ph < BLANK) return {8'hFF, 7'h7F, 1'b1, fd};
        nibv = 4'(m_shadow >> (4 * slot));
        if (slot > 0 && blank_lz && ((m_shadow >> (4 * slot)) == 32'd0)) s = 7'h7F;
        else s = HEX[nibv];
        return {~(8'd1 << slot), s, ~dp_mask[slot], fd};
    endfunction

    always @(posedge clock) begin
        exp_q.push_back(model_out());
        if (reset) begin
            m_pos    <= 0;
            m_shadow <= '0;
            m_pend   <= '0;
            m_pv     <= 1'b0;
        end else if (!enable) begin
            m_pos <= 0;
            if (load) begin
                m_shadow <= data_in;
                m_pv     <= 1'b0;
            end else if (m_pv) begin
                m_shadow <= m_pend;
                m_pv     <= 1'b0;
            end
        end else begin
            m_pos <= (m_pos == FRAME - 1) ? 0 : m_pos + 1;
            if (load && m_pos == FRAME - 1) begin
                m_shadow <= data_in;
                m_pv     <= 1'b0;
            end else if (load) begin
                m_pend <= data_in;
                m_pv   <= 1'b1;
            end else if (m_pos == FRAME - 1 && m_pv) begin
                m_shadow <= m_pend;
                m_pv     <= 1'b0;
            end
        end
    end

    always @(negedge clock) begin
        if (exp_q.size() != 0) check_eq("scoreboard", 32'({an, seg, dp, frame_done}), 32'(exp_q.pop_front()));
    end

    task automatic wait_fd();
        int i;
        for (i = 0; i < 200; i++) begin
            step(1);
            if (frame_done) break;
        end
        if (i >= 200) check_eq("frame_done_timeout", 32'd0, 32'd1);
    endtask

    // Called in the frame_done cycle; walks the following frame slot by slot.
    task automatic check_frame(input logic [55:0] segs);
        logic [7:0] exp_an;
        logic       exp_dp;
        step(1);
        for (int k = 0; k < DIGITS; k++) begin
            check_eq("guard_an", 32'(an), 32'hFF);
            step(2);
            exp_an = ~(8'd1 << k);
            exp_dp = ~dp_mask[k];
            check_eq("digit_an", 32'(an), 32'(exp_an));
            check_eq("digit_seg", 32'(seg), 32'(segs[k*7 +: 7]));
            check_eq("digit_dp", 32'(dp), 32'(exp_dp));
            step(2);
        end
    endtask

    task automatic pulse_load(input logic [31:0] d);
        data_in = d;
        load    = 1'b1;
        step(1);
        load    = 1'b0;
    endtask

    initial begin
        int n;
        step(3);
        check_eq("rst_an", 32'(an), 32'hFF);
        check_eq("rst_seg", 32'(seg), 32'h7F);
        check_eq("rst_dp", 32'(dp), 32'h1);
        check_eq("rst_fd", 32'(frame_done), 32'h0);

        reset  = 1'b0;
        enable = 1'b1;
        pulse_load(32'h89ABCDEF);
        wait_fd();
        check_frame({7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h04, 7'h0E});

        wait_fd();
        n = 0;
        do begin
            step(1);
            n++;
        end while (!frame_done && n < 100);
        check_eq("frame_period", 32'(n), 32'd32);

        wait_fd();
        step(13);
        pulse_load(32'h11111111);
        step(9);
        check_eq("tear_old_digit5", 32'(seg), 32'h08);
        wait_fd();
        step(3);
        check_eq("tear_new_an", 32'(an), 32'hFE);
        check_eq("tear_new_seg", 32'(seg), 32'h79);

        wait_fd();
        data_in = 32'h1;
        load    = 1'b1;
        step(1);
        data_in = 32'h2;
        step(1);
        load    = 1'b0;
        wait_fd();
        step(3);
        check_eq("b2b_last_wins", 32'(seg), 32'h24);

        for (int i = 0; i < 100 && m_pos != FRAME - 1; i++) step(1);
        pulse_load(32'h5);
        check_eq("bnd_fd", 32'(frame_done), 32'h1);
        step(3);
        check_eq("bnd_load_seg", 32'(seg), 32'h12);

        blank_lz = 1'b1;
        wait_fd();
        pulse_load(32'h00000305);
        wait_fd();
        check_frame({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h30, 7'h40, 7'h12});
        pulse_load(32'h0);
        wait_fd();
        check_frame({{7{7'h7F}}, 7'h40});

        blank_lz = 1'b0;
        dp_mask  = 8'h81;
        wait_fd();
        check_frame({8{7'h40}});

        wait_fd();
        step(6);
        enable = 1'b0;
        step(1);
        check_eq("dark_an", 32'(an), 32'hFF);
        check_eq("dark_seg", 32'(seg), 32'h7F);
        check_eq("dark_dp", 32'(dp), 32'h1);
        pulse_load(32'h76543210);
        step(2);
        enable = 1'b1;
        step(1);
        check_eq("wake_guard_an", 32'(an), 32'hFF);
        step(1);
        check_eq("wake_an", 32'(an), 32'hFE);
        check_eq("wake_seg", 32'(seg), 32'h40);
        check_eq("wake_dp", 32'(dp), 32'h0);

        step(10);
        reset = 1'b1;
        step(1);
        check_eq("midrst_an", 32'(an), 32'hFF);
        check_eq("midrst_seg", 32'(seg), 32'h7F);
        check_eq("midrst_fd", 32'(frame_done), 32'h0);
        step(1);
        reset = 1'b0;
        step(1);
        check_eq("post_rst_guard", 32'(an), 32'hFF);
        step(1);
        check_eq("post_rst_an", 32'(an), 32'hFE);
        check_eq("post_rst_seg", 32'(seg), 32'h40);

        repeat (600) begin
            load    = ($urandom_range(0, 7) == 0);
            data_in = $urandom >> (4 * $urandom_range(0, 7));
            if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(0, 31) == 0) dp_mask = 8'($urandom);
            if ($urandom_range(0, 99) == 0) enable = ~enable;
            if ($urandom_range(0, 299) == 0) reset = 1'b1;
            else reset = 1'b0;
            step(1);
        end
        load   = 1'b0;
        reset  = 1'b0;
        enable = 1'b1;
        step(40);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
